// File: rtl/sobel_gradient.sv
`default_nettype none
// ============================================================================
// Module      : sobel_gradient
// Description : Takes one 3x3 pixel window at a time and computes the Sobel
//               Gx/Gy gradients. It hands them to an external magnitude unit
//               and forwards the result as an edge pixel. If the magnitude
//               unit does not answer within TIMEOUT cycles, the block emits
//               SAT_VALUE and raises a sticky error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sobel_gradient #(
  parameter int         TIMEOUT   = 64,
  parameter logic [7:0] SAT_VALUE = 8'd255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               win_valid,
  output logic               win_ready,
  input  logic [71:0]        win_pix,
  output logic signed [10:0] mag_a,
  output logic signed [10:0] mag_b,
  output logic               mag_start,
  input  logic [7:0]         mag_out,
  input  logic               mag_done,
  output logic [7:0]         pix_out,
  output logic               pix_valid,
  input  logic               pix_ready,
  output logic               timeout_err
);

  localparam int                 c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CALC  = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [71:0]         r_win;
  logic [c_cnt_w-1:0]  r_cnt;
  logic signed [10:0]  w_gx;
  logic signed [10:0]  w_gy;
  logic                w_accept;
  logic                w_done;
  logic                w_expired;

  // Zero-extend pixel idx of a window to an 11-bit signed operand.
  function automatic logic signed [10:0] f_px(input logic [71:0] win, input int idx);
    return {3'b000, win[8*idx +: 8]};
  endfunction

  // Sobel kernels. The centre pixel has zero weight in both kernels. Each
  // partial sum is at most 1020, so 11-bit signed arithmetic cannot overflow.
  assign w_gx = (f_px(r_win, 2) + (f_px(r_win, 5) <<< 1) + f_px(r_win, 8))
              - (f_px(r_win, 0) + (f_px(r_win, 3) <<< 1) + f_px(r_win, 6));
  assign w_gy = (f_px(r_win, 6) + (f_px(r_win, 7) <<< 1) + f_px(r_win, 8))
              - (f_px(r_win, 0) + (f_px(r_win, 1) <<< 1) + f_px(r_win, 2));

  assign w_accept  = (r_state == S_IDLE) && win_valid;
  // A real result beats an expiring counter in the same cycle.
  assign w_done    = (r_state == S_WAIT) && mag_done;
  assign w_expired = (r_state == S_WAIT) && !mag_done && (r_cnt == c_cnt_last);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    win_ready   = 1'b0;
    mag_start   = 1'b0;
    pix_valid   = 1'b0;
    case (r_state)
      S_IDLE: begin
        win_ready = 1'b1;
        if (win_valid) w_state_nxt = S_CALC;
      end
      S_CALC:  w_state_nxt = S_START;
      S_START: begin
        mag_start   = 1'b1;
        w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (w_done || w_expired) w_state_nxt = S_OUT;
      end
      S_OUT: begin
        pix_valid = 1'b1;
        if (pix_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Wait counter: cleared while the request is issued, counts WAIT cycles.
  always_ff @(posedge clk) begin
    if (reset)                                 r_cnt <= '0;
    else if (r_state == S_START)               r_cnt <= '0;
    else if (r_state == S_WAIT && !w_expired)  r_cnt <= r_cnt + 1'b1;
  end

  // Datapath registers: window capture, gradient operands, result and error flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win       <= '0;
      mag_a       <= '0;
      mag_b       <= '0;
      pix_out     <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (w_accept) r_win <= win_pix;
      if (r_state == S_CALC) begin
        mag_a <= w_gx;
        mag_b <= w_gy;
      end
      if (w_done) begin
        pix_out <= mag_out;
      end else if (w_expired) begin
        pix_out     <= SAT_VALUE;
        timeout_err <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_gradient.sv
`default_nettype none
// ============================================================================
// Module      : tb_sobel_gradient
// Description : Self-checking bench for sobel_gradient. A behavioural
//               magnitude-unit model answers each request after a chosen
//               latency. Expected gradients, latencies and pixels come from
//               kernel-weight arithmetic applied to the window.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sobel_gradient;

  localparam int         TIMEOUT   = 64;
  localparam logic [7:0] SAT_VALUE = 8'd255;

  logic               clk;
  logic               reset;
  logic               win_valid;
  logic               win_ready;
  logic [71:0]        win_pix;
  logic signed [10:0] mag_a;
  logic signed [10:0] mag_b;
  logic               mag_start;
  logic [7:0]         mag_out;
  logic               mag_done;
  logic [7:0]         pix_out;
  logic               pix_valid;
  logic               pix_ready;
  logic               timeout_err;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_terr = 0;

  int kx [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
  int ky [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

  sobel_gradient #(
    .TIMEOUT   (TIMEOUT),
    .SAT_VALUE (SAT_VALUE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .win_valid   (win_valid),
    .win_ready   (win_ready),
    .win_pix     (win_pix),
    .mag_a       (mag_a),
    .mag_b       (mag_b),
    .mag_start   (mag_start),
    .mag_out     (mag_out),
    .mag_done    (mag_done),
    .pix_out     (pix_out),
    .pix_valid   (pix_valid),
    .pix_ready   (pix_ready),
    .timeout_err (timeout_err)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Push one window through, with the magnitude model answering after 'lat'
  // WAIT cycles (lat >= TIMEOUT means never). Then hold the output 'hold' cycles.
  task automatic run_window(input logic [7:0] p [9], input int lat, input logic [7:0] mval, input int hold);
    logic [71:0] pw;
    int          gx, gy, k, start_k, starts, exp_lat, waited;
    bit          timed_out;
    logic [7:0]  exp_pix;
    gx = 0;
    gy = 0;
    for (int i = 0; i < 9; i++) begin
      pw[8*i +: 8] = p[i];
      gx += kx[i] * int'(p[i]);
      gy += ky[i] * int'(p[i]);
    end
    timed_out = (lat >= TIMEOUT);
    exp_pix   = timed_out ? SAT_VALUE : mval;
    exp_lat   = 3 + (timed_out ? TIMEOUT - 1 : lat);
    if (timed_out) exp_terr = 1;

    waited = 0;
    while (!win_ready && waited < 50) begin
      tick();
      waited++;
    end
    check("win_ready_idle", win_ready, 1);
    win_valid = 1'b1;
    win_pix   = pw;
    tick();
    win_valid = 1'b0;
    win_pix   = {$urandom, $urandom, 8'($urandom)};

    k       = 0;
    start_k = -1;
    starts  = 0;
    while (!pix_valid) begin
      if (mag_start) begin
        starts++;
        if (start_k < 0) start_k = k;
      end
      check("win_ready_busy", win_ready, 0);
      if (k >= 1) begin
        check("mag_a", mag_a, gx);
        check("mag_b", mag_b, gy);
      end
      if (k > exp_lat + 5) begin
        check("pix_valid_wait", pix_valid, 1);
        mag_done = 1'b0;
        return;
      end
      mag_done = (start_k >= 0) && !timed_out && (k == start_k + 1 + lat);
      mag_out  = mag_done ? mval : 8'($urandom);
      tick();
      k++;
    end
    mag_done = 1'b0;
    check("latency", k, exp_lat);
    check("mag_start_pulses", starts, 1);
    check("pix_out", pix_out, exp_pix);
    check("timeout_err", timeout_err, exp_terr);

    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_pix_valid", pix_valid, 1);
      check("hold_pix_out", pix_out, exp_pix);
      check("hold_win_ready", win_ready, 0);
    end
    pix_ready = 1'b1;
    tick();
    pix_ready = 1'b0;
    check("release_win_ready", win_ready, 1);
    check("release_pix_valid", pix_valid, 0);
  endtask

  // Stimulus and checking sequence.
  initial begin
    logic [7:0] pv [9];
    reset     = 1'b1;
    win_valid = 1'b0;
    win_pix   = '0;
    mag_out   = '0;
    mag_done  = 1'b0;
    pix_ready = 1'b0;
    repeat (3) tick();
    check("rst_win_ready", win_ready, 1);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_mag_start", mag_start, 0);
    check("rst_mag_a", mag_a, 0);
    check("rst_mag_b", mag_b, 0);
    check("rst_pix_out", pix_out, 0);
    check("rst_timeout_err", timeout_err, 0);
    reset = 1'b0;
    tick();

    // Flat image: zero gradient, magnitude answers after 4 WAIT cycles.
    for (int i = 0; i < 9; i++) pv[i] = 8'd100;
    run_window(pv, 4, 8'd0, 0);

    // Vertical edge: dark left column, bright right column.
    pv = '{8'd0, 8'd128, 8'd255, 8'd0, 8'd128, 8'd255, 8'd0, 8'd128, 8'd255};
    run_window(pv, 1, 8'd255, 1);

    // Horizontal edge: bright top row, dark bottom row.
    pv = '{8'd255, 8'd255, 8'd255, 8'd50, 8'd50, 8'd50, 8'd0, 8'd0, 8'd0};
    run_window(pv, 0, 8'd255, 0);

    // Magnitude unit never answers.
    for (int i = 0; i < 9; i++) pv[i] = 8'($urandom);
    run_window(pv, 1000, 8'd17, 0);

    // Error flag stays set, and the output is held under backpressure.
    for (int i = 0; i < 9; i++) pv[i] = 8'($urandom);
    run_window(pv, 2, 8'd99, 10);

    // Reset in the middle of WAIT, then a stale mag_done shortly afterwards.
    for (int i = 0; i < 9; i++) pv[i] = 8'($urandom);
    win_pix   = {pv[8], pv[7], pv[6], pv[5], pv[4], pv[3], pv[2], pv[1], pv[0]};
    win_valid = 1'b1;
    tick();
    win_valid = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    reset    = 1'b0;
    exp_terr = 0;
    check("abort_mag_a", mag_a, 0);
    check("abort_mag_b", mag_b, 0);
    check("abort_pix_out", pix_out, 0);
    check("abort_timeout_err", timeout_err, 0);
    tick();
    mag_done = 1'b1;
    mag_out  = 8'd77;
    tick();
    mag_done = 1'b0;
    for (int c = 0; c < 10; c++) begin
      check("abort_pix_valid", pix_valid, 0);
      check("abort_win_ready", win_ready, 1);
      check("abort_mag_start", mag_start, 0);
      tick();
    end

    // Result arrives in the last allowed WAIT cycle: the real value wins.
    for (int i = 0; i < 9; i++) pv[i] = 8'($urandom);
    run_window(pv, TIMEOUT - 1, 8'd42, 0);

    // Random windows, latencies and backpressure.
    for (int n = 0; n < 12; n++) begin
      for (int i = 0; i < 9; i++) pv[i] = 8'($urandom);
      run_window(pv, int'($urandom_range(0, 8)), 8'($urandom), int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/sobel_gradient.md
SOBEL_GRADIENT -- requirements
Module: sobel_gradient

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max cycles in WAIT before abort.
REQ-002 SHALL have parameter SAT_VALUE, default 255: pixel emitted on timeout.
REQ-003 SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 win_valid  input  1  3x3 window on win_pix is valid.
REQ-007 win_ready  output  1  block accepts a window this cycle.
REQ-008 win_pix  input  72  nine 8-bit unsigned pixels, p0 at [7:0] .. p8 at [71:64], row-major, p0 top-left.
REQ-009 mag_a  output  11  signed Gx operand to the magnitude unit.
REQ-010 mag_b  output  11  signed Gy operand to the magnitude unit.
REQ-011 mag_start  output  1  one-cycle request to the magnitude unit.
REQ-012 mag_out  input  8  magnitude result, 0..255.
REQ-013 mag_done  input  1  magnitude result valid (outValid).
REQ-014 pix_out  output  8  edge pixel to downstream.
REQ-015 pix_valid  output  1  pix_out valid.
REQ-016 pix_ready  input  1  downstream accepts pix_out.
REQ-017 timeout_err  output  1  sticky flag: a magnitude request timed out.

Function
REQ-018 SHALL implement FSM states IDLE, CALC, START, WAIT, OUT.
REQ-019 IDLE: win_ready=1; on win_valid&&win_ready, register win_pix and go to CALC.
REQ-020 CALC: register Gx=(p2+2p5+p8)-(p0+2p3+p6) and Gy=(p6+2p7+p8)-(p0+2p1+p2) into mag_a/mag_b, full 11-bit signed, no truncation (range -1020..+1020); go to START.
REQ-021 START: mag_start=1 for exactly one cycle, clear timeout counter, go to WAIT.
REQ-022 mag_a/mag_b SHALL stay stable from START until leaving WAIT.
REQ-023 WAIT: on mag_done=1, capture mag_out into pix_out, go to OUT.
REQ-024 WAIT: counter increments per cycle; if it reaches TIMEOUT without mag_done, load SAT_VALUE into pix_out, set timeout_err, go to OUT.
REQ-025 mag_done arriving in the same cycle the counter reaches TIMEOUT SHALL take priority (real result used, no error).
REQ-026 mag_done outside WAIT SHALL be ignored.
REQ-027 OUT: pix_valid=1, pix_out stable; on pix_ready, go to IDLE.
REQ-028 win_ready SHALL be 0 in every state except IDLE; one window in flight max.
REQ-029 Latency window-accept to pix_valid SHALL be 3 cycles plus magnitude latency (mag_done in first WAIT cycle -> pix_valid 3 cycles after accept).
REQ-030 pix_valid SHALL be held under pix_ready=0 indefinitely with no state change.
REQ-031 timeout_err SHALL clear only on reset.

Reset
REQ-032 reset SHALL force IDLE and set win_ready=1, mag_start=0, pix_valid=0, timeout_err=0, mag_a=0, mag_b=0, pix_out=0, counter=0.
REQ-033 reset asserted in any state, including WAIT with a pending request, SHALL abort the operation; a late mag_done after reset SHALL be ignored.
REQ-034 reset SHALL take priority over all other inputs in the same cycle.

Verification
REQ-035 All pixels 100, bench magnitude model returns 0 after 4 cycles -> mag_a=0, mag_b=0, single mag_start pulse, pix_out=0, pix_valid 7 cycles after accept.
REQ-036 Left column 0, right column 255, middle 128 -> mag_a=+1020, mag_b=0; model returns 255 -> pix_out=255, timeout_err=0.
REQ-037 Top row 255, bottom row 0 -> mag_a=0, mag_b=-1020 (11'h404); model returns 255 -> pix_out=255.
REQ-038 Model never asserts mag_done -> after 64 WAIT cycles pix_out=255, timeout_err=1 and stays 1 through next window.
REQ-039 pix_ready held 0 for 10 cycles in OUT -> pix_valid and pix_out stable, win_ready=0 throughout; pix_ready=1 -> IDLE next cycle, win_ready=1.
REQ-040 reset pulsed during WAIT, mag_done pulsed 2 cycles later -> pix_valid stays 0, win_ready=1, no output produced.
